// File: rtl/axicb_slv_switch_wr_gen_if.sv
// AW/W/B channel bundle between one crossbar master and the SLV_NB slave ports of its write switch.
// Modport "slave" is the switch's view; modport "master" is the surrounding fabric's view.
interface axicb_slv_switch_wr_gen_if #(
  parameter int AXI_ADDR_W = 16,
  parameter int AXI_ID_W   = 8,
  parameter int SLV_NB     = 4,
  parameter int AWCH_W     = AXI_ADDR_W + AXI_ID_W + 8,
  parameter int WCH_W      = 8,
  parameter int BCH_W      = AXI_ID_W + 2
);
  logic                    i_awvalid;
  logic                    i_awready;
  logic [AWCH_W-1:0]       i_awch;
  logic                    i_wvalid;
  logic                    i_wready;
  logic                    i_wlast;
  logic [WCH_W-1:0]        i_wch;
  logic                    i_bvalid;
  logic                    i_bready;
  logic [BCH_W-1:0]        i_bch;
  logic [SLV_NB-1:0]       o_awvalid;
  logic [SLV_NB-1:0]       o_awready;
  logic [AWCH_W-1:0]       o_awch;
  logic [SLV_NB-1:0]       o_wvalid;
  logic [SLV_NB-1:0]       o_wready;
  logic [SLV_NB-1:0]       o_wlast;
  logic [WCH_W-1:0]        o_wch;
  logic [SLV_NB-1:0]       o_bvalid;
  logic [SLV_NB-1:0]       o_bready;
  logic [SLV_NB*BCH_W-1:0] o_bch;

  modport slave (
    input  i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
    input  o_awready, o_wready, o_bvalid, o_bch,
    output i_awready, i_wready, i_bvalid, i_bch,
    output o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready
  );

  modport master (
    output i_awvalid, i_awch, i_wvalid, i_wlast, i_wch, i_bready,
    output o_awready, o_wready, o_bvalid, o_bch,
    input  i_awready, i_wready, i_bvalid, i_bch,
    input  o_awvalid, o_awch, o_wvalid, o_wlast, o_wch, o_bready
  );
endinterface

// File: rtl/axicb_slv_switch_wr_gen.sv
// Master-side write switch: decodes AW to one of SLV_NB slaves, routes W by a route FIFO and
// returns B in order. Optional B watchdog enabled by AXICB_SLV_SWITCH_WR_TIMEOUT_EN.
module axicb_slv_switch_wr_gen #(
  parameter int AXI_ADDR_W = 16,
  parameter int AXI_ID_W   = 8,
  parameter int SLV_NB     = 4,
  parameter logic [SLV_NB-1:0] MST_ROUTES = '1,
  parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_START_ADDR =
      {16'h3000, 16'h2000, 16'h1000, 16'h0000},
  parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_END_ADDR =
      {16'h3FFF, 16'h2FFF, 16'h1FFF, 16'h0FFF},
  parameter int MST_OSTDREQ_NUM = 4,
  parameter int WFIFO_DEPTH     = 3,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int AWCH_W          = AXI_ADDR_W + AXI_ID_W + 8,
  parameter int WCH_W           = 8,
  parameter int BCH_W           = AXI_ID_W + 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic srst,
  axicb_slv_switch_wr_gen_if.slave bus,
  output logic o_timeout
);

  localparam int TGT_W  = $clog2(SLV_NB + 1);
  localparam int OSTD_W = $clog2(MST_OSTDREQ_NUM + 1);
  localparam int WF_NB  = 2 ** WFIFO_DEPTH;
  localparam int MR_AW  = (MST_OSTDREQ_NUM > 1) ? $clog2(MST_OSTDREQ_NUM) : 1;
  localparam logic [TGT_W-1:0]  MR_TGT   = TGT_W'(SLV_NB);
  localparam logic [OSTD_W-1:0] OSTD_MAX = OSTD_W'(MST_OSTDREQ_NUM);
  localparam logic [MR_AW-1:0]  MR_LAST  = MR_AW'(MST_OSTDREQ_NUM - 1);

  logic [AXI_ADDR_W-1:0]  aw_addr;
  logic [AXI_ID_W-1:0]    aw_id;
  logic [TGT_W-1:0]       tgt, cur_tgt_q, wf_head;
  logic [OSTD_W-1:0]      ostd_q, mr_bcnt_q;
  logic [WFIFO_DEPTH:0]   wf_wptr_q, wf_rptr_q;
  logic [TGT_W-1:0]       wf_mem_q [WF_NB];
  logic [MR_AW-1:0]       mr_wptr_q, mr_rptr_q;
  logic [AXI_ID_W-1:0]    mr_mem_q [MST_OSTDREQ_NUM];
  logic wf_full, wf_empty, aw_ok, aw_slv_rdy, aw_hs, w_last_hs, mr_last_hs, b_hs, mr_b_hs;
  logic ostd_nz, unused_awch;

  assign aw_addr     = bus.i_awch[AXI_ADDR_W-1:0];
  assign aw_id       = bus.i_awch[AXI_ADDR_W +: AXI_ID_W];
  assign unused_awch = ^bus.i_awch[AWCH_W-1:AXI_ADDR_W+AXI_ID_W];
  assign bus.o_awch  = bus.i_awch;
  assign bus.o_wch   = bus.i_wch;

  // Descending scan so the lowest matching slave index wins.
  always_comb begin
    tgt = MR_TGT;
    for (int i = SLV_NB - 1; i >= 0; i--) begin
      if (MST_ROUTES[i] && (aw_addr >= SLV_START_ADDR[i*AXI_ADDR_W +: AXI_ADDR_W]) &&
          (aw_addr <= SLV_END_ADDR[i*AXI_ADDR_W +: AXI_ADDR_W])) begin
        tgt = TGT_W'(i);
      end
    end
  end

  assign wf_empty = (wf_wptr_q == wf_rptr_q);
  assign wf_full  = (wf_wptr_q[WFIFO_DEPTH] != wf_rptr_q[WFIFO_DEPTH]) &&
                    (wf_wptr_q[WFIFO_DEPTH-1:0] == wf_rptr_q[WFIFO_DEPTH-1:0]);
  assign wf_head  = wf_mem_q[wf_rptr_q[WFIFO_DEPTH-1:0]];
  assign ostd_nz  = (ostd_q != '0);

  // A new target is only taken once every earlier write has returned its B.
  assign aw_ok = !wf_full && (ostd_q < OSTD_MAX) && (!ostd_nz || (tgt == cur_tgt_q));

  always_comb begin
    bus.o_awvalid = '0;
    aw_slv_rdy    = 1'b0;
    for (int i = 0; i < SLV_NB; i++) begin
      if (tgt == TGT_W'(i)) begin
        bus.o_awvalid[i] = bus.i_awvalid && aw_ok;
        aw_slv_rdy       = bus.o_awready[i];
      end
    end
  end

  assign bus.i_awready = aw_ok && ((tgt == MR_TGT) || aw_slv_rdy);
  assign aw_hs         = bus.i_awvalid && bus.i_awready;

  always_comb begin
    bus.o_wvalid = '0;
    bus.o_wlast  = '0;
    bus.i_wready = 1'b0;
    if (!wf_empty) begin
      if (wf_head == MR_TGT) begin
        bus.i_wready = 1'b1;
      end else begin
        for (int i = 0; i < SLV_NB; i++) begin
          if (wf_head == TGT_W'(i)) begin
            bus.o_wvalid[i] = bus.i_wvalid;
            bus.o_wlast[i]  = bus.i_wlast;
            bus.i_wready    = bus.o_wready[i];
          end
        end
      end
    end
  end

  assign w_last_hs  = bus.i_wvalid && bus.i_wready && bus.i_wlast;
  assign mr_last_hs = w_last_hs && (wf_head == MR_TGT);

  always_comb begin
    bus.i_bvalid = 1'b0;
    bus.i_bch    = '0;
    bus.o_bready = '0;
    if (cur_tgt_q == MR_TGT) begin
      bus.i_bvalid = (mr_bcnt_q != '0);
      bus.i_bch    = {2'b11, mr_mem_q[mr_rptr_q]};
    end else begin
      for (int i = 0; i < SLV_NB; i++) begin
        if (cur_tgt_q == TGT_W'(i)) begin
          bus.i_bvalid    = bus.o_bvalid[i] && ostd_nz;
          bus.i_bch       = bus.o_bch[i*BCH_W +: BCH_W];
          bus.o_bready[i] = bus.i_bready && ostd_nz;
        end
      end
    end
  end

  assign b_hs    = bus.i_bvalid && bus.i_bready;
  assign mr_b_hs = b_hs && (cur_tgt_q == MR_TGT);

  // Payload storage needs no reset; validity lives in the pointers.
  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      wf_mem_q[wf_wptr_q[WFIFO_DEPTH-1:0]] <= tgt;
      if (tgt == MR_TGT) mr_mem_q[mr_wptr_q] <= aw_id;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ostd_q    <= '0;
      cur_tgt_q <= '0;
      mr_bcnt_q <= '0;
      wf_wptr_q <= '0;
      wf_rptr_q <= '0;
      mr_wptr_q <= '0;
      mr_rptr_q <= '0;
    end else if (srst) begin
      ostd_q    <= '0;
      cur_tgt_q <= '0;
      mr_bcnt_q <= '0;
      wf_wptr_q <= '0;
      wf_rptr_q <= '0;
      mr_wptr_q <= '0;
      mr_rptr_q <= '0;
    end else begin
      if (aw_hs) begin
        wf_wptr_q <= wf_wptr_q + 1'b1;
        cur_tgt_q <= tgt;
        if (tgt == MR_TGT) mr_wptr_q <= (mr_wptr_q == MR_LAST) ? '0 : mr_wptr_q + 1'b1;
      end
      if (w_last_hs) wf_rptr_q <= wf_rptr_q + 1'b1;
      if (mr_b_hs) mr_rptr_q <= (mr_rptr_q == MR_LAST) ? '0 : mr_rptr_q + 1'b1;
      if (aw_hs && !b_hs) ostd_q <= ostd_q + 1'b1;
      else if (!aw_hs && b_hs) ostd_q <= ostd_q - 1'b1;
      if (mr_last_hs && !mr_b_hs) mr_bcnt_q <= mr_bcnt_q + 1'b1;
      else if (!mr_last_hs && mr_b_hs) mr_bcnt_q <= mr_bcnt_q - 1'b1;
    end
  end

`ifdef AXICB_SLV_SWITCH_WR_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else if (srst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (!ostd_nz || b_hs) begin
        wd_q <= '0;
      end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        wd_q      <= '0;
        timeout_q <= 1'b1;
      end else begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end

  assign o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axicb_slv_switch_wr_gen.sv
// Directed bench for axicb_slv_switch_wr_gen (4 slaves, 0x1000 windows, 4 outstanding).
module tb_axicb_slv_switch_wr_gen;

  logic aclk, aresetn, srst, o_timeout;
  int n_vec, n_err;

  axicb_slv_switch_wr_gen_if bus ();

  axicb_slv_switch_wr_gen #(.TIMEOUT_CYCLES(16)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .srst      (srst),
    .bus       (bus),
    .o_timeout (o_timeout)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic set_aw(input logic [15:0] addr, input logic [7:0] id);
    bus.i_awvalid = 1'b1;
    bus.i_awch    = {8'h00, id, addr};
  endtask

  task automatic send_w1(input logic [7:0] data);
    bus.i_wvalid = 1'b1;
    bus.i_wlast  = 1'b1;
    bus.i_wch    = data;
    tick();
    bus.i_wvalid = 1'b0;
    bus.i_wlast  = 1'b0;
  endtask

  task automatic drain_b(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      bus.o_bvalid    = '0;
      bus.o_bvalid[s] = 1'b1;
      bus.i_bready    = 1'b1;
      tick();
    end
    bus.o_bvalid = '0;
    bus.i_bready = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    srst = 1'b0;
    bus.i_wvalid = 1'b1;
    bus.i_bready = 1'b1;
    bus.o_bvalid = '1;
    #1;
    n_vec++;
    if ({bus.o_awvalid, bus.o_wvalid, bus.o_wlast, bus.o_bready} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_slave_side: got %h want 0000",
               {bus.o_awvalid, bus.o_wvalid, bus.o_wlast, bus.o_bready});
    end
    n_vec++;
    if ({bus.i_wready, bus.i_bvalid, o_timeout} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_master_side: got %b want 000", {bus.i_wready, bus.i_bvalid, o_timeout});
    end
    tick();
    tick();
    #2 aresetn = 1'b1;
    bus.i_wvalid = 1'b0;
    bus.i_bready = 1'b0;
    bus.o_bvalid = '0;
    tick();
  endtask

  task automatic test_single_write;
    set_aw(16'h1004, 8'h05);
    #1;
    n_vec++;
    if ({bus.o_awvalid, bus.i_awready} !== 5'b0010_1) begin
      n_err++;
      $display("FAIL single_aw: got %b want 00101", {bus.o_awvalid, bus.i_awready});
    end
    n_vec++;
    if (bus.o_awch !== 32'h0005_1004) begin
      n_err++;
      $display("FAIL single_awch: got %h want 00051004", bus.o_awch);
    end
    tick();
    bus.i_awvalid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.i_wvalid = 1'b1;
      bus.i_wlast  = (b == 3);
      bus.i_wch    = 8'h10 + 8'(b);
      #1;
      n_vec++;
      if ({bus.o_wvalid, bus.o_wlast, bus.o_wch, bus.i_wready} !==
          {4'b0010, (b == 3) ? 4'b0010 : 4'b0000, 8'h10 + 8'(b), 1'b1}) begin
        n_err++;
        $display("FAIL single_w%0d: got %h want %h", b,
                 {bus.o_wvalid, bus.o_wlast, bus.o_wch, bus.i_wready},
                 {4'b0010, (b == 3) ? 4'b0010 : 4'b0000, 8'h10 + 8'(b), 1'b1});
      end
      tick();
    end
    bus.i_wvalid = 1'b0;
    bus.i_wlast  = 1'b0;
    bus.o_bch    = {10'h155, 10'h2CC, 10'h005, 10'h3FF};
    bus.o_bvalid = 4'b1011;
    bus.i_bready = 1'b1;
    #1;
    n_vec++;
    if ({bus.i_bvalid, bus.i_bch, bus.o_bready} !== {1'b1, 10'h005, 4'b0010}) begin
      n_err++;
      $display("FAIL single_b: got %h want %h", {bus.i_bvalid, bus.i_bch, bus.o_bready},
               {1'b1, 10'h005, 4'b0010});
    end
    tick();
    n_vec++;
    if ({bus.i_bvalid, bus.o_bready} !== 5'b0_0000) begin
      n_err++;
      $display("FAIL single_ostd_zero: got %b want 00000", {bus.i_bvalid, bus.o_bready});
    end
    bus.o_bvalid = '0;
    bus.i_bready = 1'b0;
  endtask

  task automatic test_same_target_block;
    set_aw(16'h0010, 8'h01);
    tick();
    bus.i_awvalid = 1'b0;
    send_w1(8'h21);
    set_aw(16'h2000, 8'h02);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++;
      if ({bus.i_awready, bus.o_awvalid} !== 5'b0_0000) begin
        n_err++;
        $display("FAIL block_stall%0d: got %b want 00000", c, {bus.i_awready, bus.o_awvalid});
      end
      tick();
    end
    bus.o_bvalid = 4'b0001;
    bus.o_bch    = {30'h0, 10'h001};
    bus.i_bready = 1'b1;
    #1;
    n_vec++;
    if ({bus.i_bvalid, bus.i_awready} !== 2'b10) begin
      n_err++;
      $display("FAIL block_b_cycle: got %b want 10", {bus.i_bvalid, bus.i_awready});
    end
    tick();
    bus.o_bvalid = '0;
    bus.i_bready = 1'b0;
    #1;
    n_vec++;
    if ({bus.i_awready, bus.o_awvalid} !== 5'b1_0100) begin
      n_err++;
      $display("FAIL block_release: got %b want 10100", {bus.i_awready, bus.o_awvalid});
    end
    tick();
    bus.i_awvalid = 1'b0;
    send_w1(8'h22);
    drain_b(2, 1);
  endtask

  task automatic test_misroute;
    set_aw(16'h8000, 8'h3A);
    #1;
    n_vec++;
    if ({bus.i_awready, bus.o_awvalid} !== 5'b1_0000) begin
      n_err++;
      $display("FAIL mr_aw: got %b want 10000", {bus.i_awready, bus.o_awvalid});
    end
    tick();
    bus.i_awvalid = 1'b0;
    bus.o_bvalid  = '1;
    for (int b = 0; b < 2; b++) begin
      bus.i_wvalid = 1'b1;
      bus.i_wlast  = (b == 1);
      #1;
      n_vec++;
      if ({bus.i_wready, bus.o_wvalid, bus.i_bvalid} !== 6'b1_0000_0) begin
        n_err++;
        $display("FAIL mr_w%0d: got %b want 100000", b, {bus.i_wready, bus.o_wvalid, bus.i_bvalid});
      end
      tick();
    end
    bus.i_wvalid = 1'b0;
    bus.i_wlast  = 1'b0;
    #1;
    n_vec++;
    if ({bus.i_bvalid, bus.i_bch} !== {1'b1, 10'h33A}) begin
      n_err++;
      $display("FAIL mr_b: got %h want %h", {bus.i_bvalid, bus.i_bch}, {1'b1, 10'h33A});
    end
    bus.i_bready = 1'b1;
    #1;
    n_vec++;
    if (bus.o_bready !== 4'b0000) begin
      n_err++;
      $display("FAIL mr_bready: got %b want 0000", bus.o_bready);
    end
    tick();
    bus.i_bready = 1'b0;
    #1;
    n_vec++;
    if (bus.i_bvalid !== 1'b0) begin
      n_err++;
      $display("FAIL mr_b_done: got %b want 0", bus.i_bvalid);
    end
    bus.o_bvalid = '0;
  endtask

  task automatic test_ostd_limit;
    for (int k = 0; k < 4; k++) begin
      set_aw(16'h2000 + 16'(k * 16), 8'(k));
      #1;
      n_vec++;
      if ({bus.i_awready, bus.o_awvalid} !== 5'b1_0100) begin
        n_err++;
        $display("FAIL ostd_acc%0d: got %b want 10100", k, {bus.i_awready, bus.o_awvalid});
      end
      tick();
    end
    set_aw(16'h2040, 8'h04);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++;
      if ({bus.i_awready, bus.o_awvalid} !== 5'b0_0000) begin
        n_err++;
        $display("FAIL ostd_full%0d: got %b want 00000", c, {bus.i_awready, bus.o_awvalid});
      end
      tick();
    end
    bus.o_bvalid = 4'b0100;
    bus.i_bready = 1'b1;
    tick();
    bus.o_bvalid = '0;
    bus.i_bready = 1'b0;
    #1;
    n_vec++;
    if (bus.i_awready !== 1'b1) begin
      n_err++;
      $display("FAIL ostd_freed: got %b want 1", bus.i_awready);
    end
    tick();
    bus.i_awvalid = 1'b0;
    for (int k = 0; k < 5; k++) send_w1(8'(k));
    drain_b(2, 4);
    bus.o_bvalid = 4'b0100;
    bus.i_bready = 1'b1;
    #1;
    n_vec++;
    if ({bus.i_bvalid, bus.o_bready} !== 5'b0_0000) begin
      n_err++;
      $display("FAIL ostd_drained: got %b want 00000", {bus.i_bvalid, bus.o_bready});
    end
    bus.o_bvalid = '0;
    bus.i_bready = 1'b0;
  endtask

  task automatic test_w_before_aw;
    bus.i_wvalid = 1'b1;
    bus.i_wlast  = 1'b1;
    bus.i_wch    = 8'hC3;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if ({bus.i_wready, bus.o_wvalid} !== 5'b0_0000) begin
        n_err++;
        $display("FAIL wfirst_wait%0d: got %b want 00000", c, {bus.i_wready, bus.o_wvalid});
      end
      tick();
    end
    set_aw(16'h3000, 8'h07);
    #1;
    n_vec++;
    if ({bus.i_awready, bus.i_wready} !== 2'b10) begin
      n_err++;
      $display("FAIL wfirst_aw_cycle: got %b want 10", {bus.i_awready, bus.i_wready});
    end
    tick();
    bus.i_awvalid = 1'b0;
    #1;
    n_vec++;
    if ({bus.o_wvalid, bus.o_wlast, bus.o_wch, bus.i_wready} !==
        {4'b1000, 4'b1000, 8'hC3, 1'b1}) begin
      n_err++;
      $display("FAIL wfirst_fwd: got %h want %h", {bus.o_wvalid, bus.o_wlast, bus.o_wch,
               bus.i_wready}, {4'b1000, 4'b1000, 8'hC3, 1'b1});
    end
    tick();
    bus.i_wvalid = 1'b0;
    bus.i_wlast  = 1'b0;
    drain_b(3, 1);
  endtask

  task automatic test_timeout;
    logic exp;
    set_aw(16'h1000, 8'h09);
    tick();
    bus.i_awvalid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
`ifdef AXICB_SLV_SWITCH_WR_TIMEOUT_EN
      exp = (c == 16) || (c == 32);
`else
      exp = 1'b0;
`endif
      n_vec++;
      if (o_timeout !== exp) begin
        n_err++;
        $display("FAIL timeout_c%0d: got %b want %b", c, o_timeout, exp);
      end
    end
    send_w1(8'h55);
    drain_b(1, 1);
  endtask

  task automatic test_srst;
    set_aw(16'h1000, 8'h0B);
    tick();
    bus.i_awvalid = 1'b0;
    bus.i_wvalid  = 1'b1;
    bus.i_wlast   = 1'b0;
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    bus.o_bvalid = '1;
    bus.i_bready = 1'b1;
    #1;
    n_vec++;
    if ({bus.i_wready, bus.o_wvalid, bus.i_bvalid, bus.o_bready} !== 10'h000) begin
      n_err++;
      $display("FAIL srst_flush: got %b want 0000000000",
               {bus.i_wready, bus.o_wvalid, bus.i_bvalid, bus.o_bready});
    end
    bus.o_bvalid = '0;
    bus.i_bready = 1'b0;
    bus.i_wvalid = 1'b0;
    set_aw(16'h0000, 8'h01);
    #1;
    n_vec++;
    if ({bus.i_awready, bus.o_awvalid} !== 5'b1_0001) begin
      n_err++;
      $display("FAIL srst_new_aw: got %b want 10001", {bus.i_awready, bus.o_awvalid});
    end
    tick();
    bus.i_awvalid = 1'b0;
    send_w1(8'h77);
    drain_b(0, 1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.i_awvalid = 1'b0;
    bus.i_awch    = '0;
    bus.i_wvalid  = 1'b0;
    bus.i_wlast   = 1'b0;
    bus.i_wch     = '0;
    bus.i_bready  = 1'b0;
    bus.o_awready = '1;
    bus.o_wready  = '1;
    bus.o_bvalid  = '0;
    bus.o_bch     = '0;
    test_reset();
    test_single_write();
    test_same_target_block();
    test_misroute();
    test_ostd_limit();
    test_w_before_aw();
    test_timeout();
    test_srst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
